// File: rtl/fir_pkg.sv
// Shared definitions for the band FIR filters: FSM states, band selectors,
// accumulator sizing and the round-half-up bias.
package fir_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } fir_state_e;

  localparam int BAND_BAJA  = 0;
  localparam int BAND_MEDIA = 1;
  localparam int BAND_ALTA  = 2;

  // Number of entries stored per coefficient table; taps beyond it read as zero.
  localparam int COEF_LEN = 16;

  function automatic int acc_width(input int width, input int taps);
    return 2 * width + $clog2(taps);
  endfunction

  function automatic int idx_width(input int taps);
    return $clog2(taps);
  endfunction

  function automatic int unsigned round_bias(input int frac);
    return 32'd1 << (frac - 1);
  endfunction

endpackage

// File: rtl/fir_coef_rom.sv
// Combinational coefficient ROM: three Q.10 tables (low, mid, high band)
// selected by band and indexed by tap number.
module fir_coef_rom
  import fir_pkg::*;
#(
  parameter int Width = 22,
  parameter int Taps  = 16
) (
  input  logic [1:0]                  band,
  input  logic [idx_width(Taps)-1:0]  idx,
  output logic signed [Width-1:0]     coef
);

  localparam logic signed [15:0] COEF_BAJA [COEF_LEN] = '{
    16'sd10,  16'sd20,  16'sd40,  16'sd60,  16'sd80,  16'sd100, 16'sd120, 16'sd120,
    16'sd120, 16'sd120, 16'sd100, 16'sd80,  16'sd60,  16'sd40,  16'sd20,  16'sd10
  };

  localparam logic signed [15:0] COEF_MEDIA [COEF_LEN] = '{
    -16'sd10, -16'sd20, -16'sd30, 16'sd0,   16'sd40,  16'sd80,  16'sd110,  16'sd130,
    16'sd130, 16'sd110, 16'sd80,  16'sd40,  16'sd0,  -16'sd30, -16'sd20,  -16'sd10
  };

  localparam logic signed [15:0] COEF_ALTA [COEF_LEN] = '{
    16'sd5,   -16'sd10, 16'sd15,  -16'sd20, 16'sd25,  -16'sd40, 16'sd60,  -16'sd300,
    16'sd300, -16'sd60, 16'sd40,  -16'sd25, 16'sd20,  -16'sd15, 16'sd10,  -16'sd5
  };

  logic [3:0] sel;

  assign sel = 4'(idx);

  always_comb begin
    coef = '0;
    if (int'(idx) < COEF_LEN) begin
      case (band)
        2'(BAND_BAJA):  coef = Width'(COEF_BAJA[sel]);
        2'(BAND_MEDIA): coef = Width'(COEF_MEDIA[sel]);
        2'(BAND_ALTA):  coef = Width'(COEF_ALTA[sel]);
        default:        coef = '0;
      endcase
    end
  end

endmodule

// File: rtl/filtro_fir_banda.sv
// Time-multiplexed band FIR: one signed MAC per clock over a Taps-deep delay line.
// Define FIR_SATURATE_EN to clamp the rounded result instead of wrapping it.
module filtro_fir_banda
  import fir_pkg::*;
#(
  parameter int Width = 22,
  parameter int Frac  = 10,
  parameter int Taps  = 16,
  parameter int BAND  = BAND_BAJA
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic signed [Width-1:0] x_in,
  output logic signed [Width-1:0] y_out,
  output logic                    busy,
  output logic                    done
);

  localparam int AccW = acc_width(Width, Taps);
  localparam int IdxW = idx_width(Taps);
  localparam logic signed [AccW-1:0] RoundK = $signed(AccW'(round_bias(Frac)));

  fir_state_e                   state;
  logic [Taps-1:0][Width-1:0]   delay;
  logic [IdxW-1:0]              idx;
  logic signed [AccW-1:0]       acc;
  logic signed [AccW-1:0]       rounded;
  logic signed [AccW-1:0]       shifted;
  logic signed [Width-1:0]      coef;
  logic signed [Width-1:0]      y_next;
  logic signed [2*Width-1:0]    prod;

  fir_coef_rom #(
    .Width (Width),
    .Taps  (Taps)
  ) u_rom (
    .band (2'(BAND)),
    .idx  (idx),
    .coef (coef)
  );

  assign prod    = (2*Width)'($signed(delay[idx])) * (2*Width)'(coef);
  assign rounded = acc + RoundK;
  assign shifted = rounded >>> Frac;

`ifdef FIR_SATURATE_EN
  localparam logic signed [AccW-1:0] MaxV = $signed({{(AccW-Width+1){1'b0}}, {(Width-1){1'b1}}});
  localparam logic signed [AccW-1:0] MinV = $signed({{(AccW-Width+1){1'b1}}, {(Width-1){1'b0}}});

  always_comb begin
    y_next = Width'(shifted);
    if (shifted > MaxV) begin
      y_next = Width'(MaxV);
    end else if (shifted < MinV) begin
      y_next = Width'(MinV);
    end
  end
`else
  assign y_next = Width'(shifted);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      delay <= '0;
      idx   <= '0;
      acc   <= '0;
      y_out <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            delay <= {delay[Taps-2:0], x_in};
            idx   <= '0;
            acc   <= '0;
            busy  <= 1'b1;
            state <= MAC;
          end
        end
        MAC: begin
          acc <= acc + AccW'(prod);
          // idx parks on the last tap so it never indexes past the delay line
          if (idx == IdxW'(Taps - 1)) begin
            state <= OUT;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        OUT: begin
          y_out <= y_next;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_filtro_fir_banda.sv
// Directed bench: low/mid/high instances share one stimulus stream and are
// checked against hand-derived impulse, DC and overflow responses.
module tb_filtro_fir_banda;
  import fir_pkg::*;

  localparam int W   = 22;
  localparam int F   = 10;
  localparam int T   = 16;
  localparam int LAT = T + 1;
  // OUT returns to IDLE, so a held start is taken one edge after done rises
  localparam int B2B = T + 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic signed [W-1:0] x_in = '0;
  logic signed [W-1:0] y_b, y_m, y_a;
  logic busy_b, busy_m, busy_a;
  logic done_b, done_m, done_a;

  filtro_fir_banda #(.Width(W), .Frac(F), .Taps(T), .BAND(BAND_BAJA)) u_baja (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in),
    .y_out(y_b), .busy(busy_b), .done(done_b)
  );
  filtro_fir_banda #(.Width(W), .Frac(F), .Taps(T), .BAND(BAND_MEDIA)) u_media (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in),
    .y_out(y_m), .busy(busy_m), .done(done_m)
  );
  filtro_fir_banda #(.Width(W), .Frac(F), .Taps(T), .BAND(BAND_ALTA)) u_alta (
    .clk(clk), .reset(reset), .start(start), .x_in(x_in),
    .y_out(y_a), .busy(busy_a), .done(done_a)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic signed [W-1:0] x;
    int eb;
    int em;
    int ea;
  } vec_t;

  vec_t vt[$];

  int imp_b[16] = '{10, 20, 40, 60, 80, 100, 120, 120, 120, 120, 100, 80, 60, 40, 20, 10};
  int imp_m[16] = '{-10, -20, -30, 0, 40, 80, 110, 130, 130, 110, 80, 40, 0, -30, -20, -10};
  int imp_a[16] = '{5, -10, 15, -20, 25, -40, 60, -300, 300, -60, 40, -25, 20, -15, 10, -5};
  int dc_b[16]  = '{10, 30, 70, 130, 210, 310, 430, 550, 670, 790, 890, 970, 1030, 1070, 1090, 1100};
  int dc_m[16]  = '{-10, -30, -60, -60, -20, 60, 170, 300, 430, 540, 620, 660, 660, 630, 610, 600};
  int dc_a[16]  = '{5, -5, 10, -10, 15, -25, 35, -265, 35, -25, 15, -10, 10, -5, 5, 0};

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Round-half-up, arithmetic shift, then clamp or keep the low 22 bits.
  function automatic longint fold(input longint s);
    longint r;
`ifndef FIR_SATURATE_EN
    logic [63:0] t;
`endif
    r = (s + 512) >>> 10;
`ifdef FIR_SATURATE_EN
    if (r > 2097151) r = 2097151;
    else if (r < -2097152) r = -2097152;
    return r;
`else
    t = r;
    return longint'($signed(t[21:0]));
`endif
  endfunction

  task automatic apply(input logic signed [W-1:0] x, input int eb, input int em, input int ea,
                       input string tag);
    int cyc;
    bit got;
    @(negedge clk);
    start = 1'b1;
    x_in  = x;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_b) got = 1'b1;
    end
    chk({tag, ".latency"}, cyc, LAT);
    chk({tag, ".y_low"}, y_b, eb);
    chk({tag, ".y_mid"}, y_m, em);
    chk({tag, ".y_high"}, y_a, ea);
    chk({tag, ".done_mid_high"}, {done_m, done_a}, 2'b11);
    chk({tag, ".busy_at_done"}, busy_b, 0);
  endtask

  initial begin
    int nd;
    int cyc;
    int got;
    int last;
    int s_b, s_m, s_a;
    int b2b_b[5] = '{40, 60, 80, 100, 120};
    int b2b_m[5] = '{-30, 0, 40, 80, 110};
    int b2b_a[5] = '{15, -20, 25, -40, 60};
    logic signed [W-1:0] cap_b, cap_m, cap_a;

    for (int i = 0; i < 16; i++)
      vt.push_back('{x: (i == 0) ? 22'sd1024 : 22'sd0, eb: imp_b[i], em: imp_m[i], ea: imp_a[i]});
    for (int i = 0; i < 16; i++)
      vt.push_back('{x: 22'sd1024, eb: dc_b[i], em: dc_m[i], ea: dc_a[i]});
    // Delay line starts full of 1024 and fills with the full-scale sample.
    for (int i = 0; i < 16; i++)
      vt.push_back('{x: 22'sd2097151,
                     eb: int'(fold(64'sd2097151 * dc_b[i] + 64'sd1024 * (dc_b[15] - dc_b[i]))),
                     em: int'(fold(64'sd2097151 * dc_m[i] + 64'sd1024 * (dc_m[15] - dc_m[i]))),
                     ea: int'(fold(64'sd2097151 * dc_a[i] + 64'sd1024 * (dc_a[15] - dc_a[i])))});
`ifdef FIR_SATURATE_EN
    vt[47].eb = 2097151;
`else
    vt[47].eb = -1941505;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in.y_low", y_b, 0);
    chk("rst_in.busy_low", busy_b, 0);
    chk("rst_in.done_low", done_b, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst.y_all", {y_b, y_m, y_a}, 0);
    chk("rst.busy_all", {busy_b, busy_m, busy_a}, 0);
    chk("rst.done_all", {done_b, done_m, done_a}, 0);

    for (int i = 0; i < vt.size(); i++)
      apply(vt[i].x, vt[i].eb, vt[i].em, vt[i].ea, $sformatf("vec%0d", i));

    // Reset asserted after E5 of an accepted sample
    @(negedge clk);
    start = 1'b1;
    x_in  = 22'sd1024;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst.busy_before", busy_b, 1);
    reset = 1'b0;
    #1;
    chk("midrst.y_low", y_b, 0);
    chk("midrst.y_mid_high", {y_m, y_a}, 0);
    chk("midrst.busy_all", {busy_b, busy_m, busy_a}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    nd = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done_b || done_m || done_a) nd++;
    end
    chk("midrst.no_done", nd, 0);
    chk("midrst.y_after", y_b, 0);
    chk("midrst.busy_after", busy_b, 0);

    // Second start three cycles after the first must be dropped
    @(negedge clk);
    start = 1'b1;
    x_in  = 22'sd1024;
    @(negedge clk);
    start = 1'b0;
    x_in  = 22'sd0;
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    x_in  = 22'sd500;
    @(negedge clk);
    start = 1'b0;
    x_in  = 22'sd0;
    nd = 0;
    cyc = 0;
    last = 0;
    cap_b = '0;
    cap_m = '0;
    cap_a = '0;
    repeat (40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_b) begin
        nd++;
        last = cyc;
        cap_b = y_b;
        cap_m = y_m;
        cap_a = y_a;
      end
    end
    chk("drop.done_count", nd, 1);
    chk("drop.latency_from_2nd", last, LAT - 3);
    chk("drop.y_low", cap_b, 10);
    chk("drop.y_mid", cap_m, -10);
    chk("drop.y_high", cap_a, 5);
    apply(22'sd0, 20, -20, -10, "drop.next");

    // start held high: one output per accepted sample, none lost or repeated
    @(negedge clk);
    start = 1'b1;
    x_in  = 22'sd0;
    got = 0;
    cyc = 0;
    last = 0;
    while (got < 5 && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      if (done_b) begin
        s_b = y_b;
        s_m = y_m;
        s_a = y_a;
        chk($sformatf("b2b%0d.y_low", got), s_b, b2b_b[got]);
        chk($sformatf("b2b%0d.y_mid", got), s_m, b2b_m[got]);
        chk($sformatf("b2b%0d.y_high", got), s_a, b2b_a[got]);
        if (got > 0) chk($sformatf("b2b%0d.period", got), cyc - last, B2B);
        last = cyc;
        got++;
        if (got == 5) start = 1'b0;
      end
    end
    start = 1'b0;
    chk("b2b.done_count", got, 5);
    nd = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (done_b) nd++;
    end
    chk("b2b.no_extra_done", nd, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
